// File: rtl/qspi_flash_responder_if.sv
// Pad and backing-memory signals of the QSPI flash responder.
// Memory handshake: mem_rd is a one-cycle strobe with mem_addr; mem_rdata is valid exactly one clk later.
interface qspi_flash_responder_if #(
  parameter int ADDR_W = 24
) ();
  logic              spi_sck;
  logic              spi_csn;
  logic [3:0]        dq_in;
  logic [3:0]        dq_out;
  logic [3:0]        dq_oe;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport slave (
    input  spi_sck, spi_csn, dq_in, mem_rdata,
    output dq_out, dq_oe, mem_rd, mem_addr
  );

  modport master (
    output spi_sck, spi_csn, dq_in, mem_rdata,
    input  dq_out, dq_oe, mem_rd, mem_addr
  );
endinterface

// File: rtl/qspi_flash_responder.sv
// SPI-flash target answering quad-output fast read (0x6B) and JEDEC-ID (0x9F) in SPI mode 0,
// oversampling SCK/CSn with the system clock and reading bytes from a synchronous memory.
module qspi_flash_responder #(
  parameter int          ADDR_W       = 24,
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  qspi_flash_responder_if.slave bus,
  output logic                  txn_done,
  output logic [15:0]           bytes_sent,
  output logic                  cmd_err,
  output logic [2:0]            state_dbg
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_QDATA  = 3'd4;
  localparam logic [2:0] S_IDDATA = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, csn_sync_q, csn_sync_d;
  logic                   sck_d_q;
  logic [2:0]             state_q, state_d;
  logic [15:0]            bit_cnt_q, bit_cnt_d;
  logic [22:0]            shift_q, shift_d;
  logic [23:0]            id_shift_q, id_shift_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [7:0]             cur_byte_q, cur_byte_d, next_byte_q, next_byte_d;
  logic                   phase_q, phase_d;
  logic                   rd_dly_q;
  logic [3:0]             dq_out_q, dq_out_d, dq_oe_q, dq_oe_d;
  logic                   mem_rd_q, mem_rd_d;
  logic                   txn_done_q, txn_done_d, cmd_err_q, cmd_err_d;
  logic [15:0]            bytes_sent_q, bytes_sent_d;

  logic        sck_s, csn_s, rise, fall;
  logic [23:0] shift_in;

  assign sck_sync_d = (sck_sync_q << 1) | {{(SYNC_STAGES-1){1'b0}}, bus.spi_sck};
  assign csn_sync_d = (csn_sync_q << 1) | {{(SYNC_STAGES-1){1'b0}}, bus.spi_csn};
  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign csn_s      = csn_sync_q[SYNC_STAGES-1];
  assign rise       = sck_s & ~sck_d_q;
  assign fall       = ~sck_s & sck_d_q;
  assign shift_in   = {shift_q, bus.dq_in[0]};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    id_shift_d   = id_shift_q;
    addr_d       = addr_q;
    cur_byte_d   = cur_byte_q;
    phase_d      = phase_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = dq_oe_q;
    bytes_sent_d = bytes_sent_q;
    mem_rd_d     = 1'b0;
    txn_done_d   = 1'b0;
    cmd_err_d    = 1'b0;
    // Memory data lands one clk after the strobe leaves this block.
    next_byte_d  = rd_dly_q ? bus.mem_rdata : next_byte_q;

    if (csn_s) begin
      state_d    = S_IDLE;
      dq_oe_d    = 4'h0;
      dq_out_d   = 4'h0;
      bit_cnt_d  = '0;
      phase_d    = 1'b0;
      txn_done_d = (state_q == S_QDATA) && (bytes_sent_q != 16'd0);
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_CMD;
          bit_cnt_d = '0;
        end
        S_CMD: if (rise) begin
          shift_d   = shift_in[22:0];
          bit_cnt_d = bit_cnt_q + 16'd1;
          if (bit_cnt_q == 16'd7) begin
            bit_cnt_d = '0;
            case (shift_in[7:0])
              8'h6B: begin
                state_d      = S_ADDR;
                bytes_sent_d = '0;
              end
              8'h9F: begin
                state_d    = S_IDDATA;
                dq_oe_d    = 4'b0010;
                id_shift_d = JEDEC_ID;
              end
              default: begin
                state_d   = S_IGNORE;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end
        S_ADDR: if (rise) begin
          shift_d   = shift_in[22:0];
          bit_cnt_d = bit_cnt_q + 16'd1;
          if (bit_cnt_q == 16'd23) begin
            addr_d    = shift_in[ADDR_W-1:0];
            mem_rd_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_DUMMY;
          end
        end
        S_DUMMY: if (rise) begin
          bit_cnt_d = bit_cnt_q + 16'd1;
          if (bit_cnt_q == 16'(DUMMY_CYCLES - 1)) begin
            bit_cnt_d  = '0;
            state_d    = S_QDATA;
            cur_byte_d = next_byte_q;
            dq_oe_d    = 4'hF;
            phase_d    = 1'b0;
          end
        end
        S_QDATA: begin
          // phase_q = 0: the nibble on the wire is the high half of cur_byte.
          if (fall) dq_out_d = phase_q ? cur_byte_q[3:0] : cur_byte_q[7:4];
          if (rise) begin
            if (!phase_q) begin
              addr_d   = addr_q + ADDR_W'(1);
              mem_rd_d = 1'b1;
            end else begin
              cur_byte_d = next_byte_q;
              if (bytes_sent_q != 16'hFFFF) bytes_sent_d = bytes_sent_q + 16'd1;
            end
            phase_d = ~phase_q;
          end
        end
        S_IDDATA: if (fall) begin
          dq_out_d   = {2'b00, id_shift_q[23], 1'b0};
          id_shift_d = id_shift_q << 1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q   <= '0;
      csn_sync_q   <= '1;
      sck_d_q      <= 1'b0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      id_shift_q   <= '0;
      addr_q       <= '0;
      cur_byte_q   <= '0;
      next_byte_q  <= '0;
      phase_q      <= 1'b0;
      rd_dly_q     <= 1'b0;
      dq_out_q     <= '0;
      dq_oe_q      <= '0;
      mem_rd_q     <= 1'b0;
      txn_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      bytes_sent_q <= '0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      csn_sync_q   <= csn_sync_d;
      sck_d_q      <= sck_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      id_shift_q   <= id_shift_d;
      addr_q       <= addr_d;
      cur_byte_q   <= cur_byte_d;
      next_byte_q  <= next_byte_d;
      phase_q      <= phase_d;
      rd_dly_q     <= mem_rd_q;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      mem_rd_q     <= mem_rd_d;
      txn_done_q   <= txn_done_d;
      cmd_err_q    <= cmd_err_d;
      bytes_sent_q <= bytes_sent_d;
    end
  end

  assign bus.dq_out   = dq_out_q;
  assign bus.dq_oe    = dq_oe_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = addr_q;
  assign txn_done     = txn_done_q;
  assign cmd_err      = cmd_err_q;
  assign bytes_sent   = bytes_sent_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: drives SPI transactions and scores DQ nibbles, memory reads and
// status pulses against expectations derived from the flash command rules.
module tb_qspi_flash_responder;
  localparam int ADDR_W = 24;
  localparam int DUMMY  = 8;
  localparam int SYNC   = 2;
  localparam int HALF   = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        txn_done, cmd_err;
  logic [15:0] bytes_sent;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  qspi_flash_responder_if #(.ADDR_W(ADDR_W)) bus ();

  qspi_flash_responder #(
    .ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY), .JEDEC_ID(24'hEF4018), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .txn_done(txn_done), .bytes_sent(bytes_sent), .cmd_err(cmd_err), .state_dbg(state_dbg)
  );

  logic [7:0]  mem [logic [23:0]];
  logic [23:0] exp_addr_q[$];
  logic [9:0]  exp_dq_q[$];   // {kind, oe, out}: kind 0 quad, 1 id bit on DQ1, 2 oe only
  logic [1:0]  exp_evt_q[$];  // {txn_done, cmd_err}
  int          tests_run = 0;
  int          fail_cnt  = 0;
  bit          mon_en    = 1'b0;
  logic [9:0]  dq_e;
  logic [23:0] addr_e;
  logic [1:0]  evt_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests_run++;
    fail_cnt++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  function automatic logic [7:0] model_byte(input logic [23:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;

  // DQ monitor: the initiator samples on each rising SCK.
  always @(posedge bus.spi_sck) begin
    if (mon_en) begin
      if (exp_dq_q.size() == 0) unexpected("dq_extra", 32'({bus.dq_oe, bus.dq_out}));
      else begin
        dq_e = exp_dq_q.pop_front();
        case (dq_e[9:8])
          2'd0:    check("dq_quad", 32'({bus.dq_oe, bus.dq_out}), 32'(dq_e[7:0]));
          2'd1:    check("dq_id", 32'({bus.dq_oe, bus.dq_out[1]}), 32'({dq_e[7:4], dq_e[1]}));
          default: check("dq_oe_off", 32'(bus.dq_oe), 32'(dq_e[7:4]));
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_rd) begin
      if (exp_addr_q.size() == 0) unexpected("mem_rd_extra", 32'(bus.mem_addr));
      else begin
        addr_e = exp_addr_q.pop_front();
        check("mem_addr", 32'(bus.mem_addr), 32'(addr_e));
      end
    end
    if (txn_done || cmd_err) begin
      if (exp_evt_q.size() == 0) unexpected("event_extra", 32'({txn_done, cmd_err}));
      else begin
        evt_e = exp_evt_q.pop_front();
        check("event", 32'({txn_done, cmd_err}), 32'(evt_e));
      end
    end
  end

  task automatic sck_cycle(input logic [3:0] d);
    bus.dq_in = d;
    repeat (HALF) @(negedge clk);
    bus.spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sck_cycle({3'b000, v[i]});
  endtask

  task automatic cs_low();
    bus.spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    bus.spi_csn = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic drain(input string name);
    check({name, "_addr_left"}, 32'(exp_addr_q.size()), 0);
    check({name, "_dq_left"}, 32'(exp_dq_q.size()), 0);
    check({name, "_evt_left"}, 32'(exp_evt_q.size()), 0);
    exp_addr_q.delete();
    exp_dq_q.delete();
    exp_evt_q.delete();
  endtask

  // Expected quad read of n nibbles from a: one fetch for the address, one per high nibble.
  task automatic push_quad(input logic [23:0] a, input int n);
    logic [7:0] b;
    for (int j = 0; j <= (n + 1) / 2; j++) exp_addr_q.push_back(a + 24'(j));
    for (int i = 0; i < n; i++) begin
      b = model_byte(a + 24'(i / 2));
      exp_dq_q.push_back({2'd0, 4'hF, (i % 2 == 0) ? b[7:4] : b[3:0]});
    end
  endtask

  task automatic quad_read(input logic [23:0] a, input int n);
    push_quad(a, n);
    if (n / 2 >= 1) exp_evt_q.push_back(2'b10);
    cs_low();
    send_bits(32'h6B, 8);
    send_bits(32'(a), 24);
    send_bits(0, DUMMY);
    mon_en = 1'b1;
    for (int i = 0; i < n; i++) sck_cycle(4'h0);
    mon_en = 1'b0;
    cs_high();
    check("bytes_sent", 32'(bytes_sent), 32'(n / 2));
    drain("quad");
  endtask

  task automatic id_read();
    logic [23:0] id;
    id = 24'hEF4018;
    for (int i = 23; i >= 0; i--) exp_dq_q.push_back({2'd1, 4'b0010, 2'b00, id[i], 1'b0});
    cs_low();
    send_bits(32'h9F, 8);
    mon_en = 1'b1;
    for (int i = 0; i < 24; i++) sck_cycle(4'h0);
    mon_en = 1'b0;
    cs_high();
    drain("id");
  endtask

  task automatic bad_cmd(input logic [7:0] op, input int extra);
    exp_evt_q.push_back(2'b01);
    for (int i = 0; i < extra; i++) exp_dq_q.push_back({2'd2, 4'h0, 4'h0});
    cs_low();
    send_bits(32'(op), 8);
    mon_en = 1'b1;
    for (int i = 0; i < extra; i++) sck_cycle(4'($urandom));
    mon_en = 1'b0;
    cs_high();
    drain("bad_cmd");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a;
    logic [7:0]  op;
    reset = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_csn = 1'b1;
    bus.dq_in   = 4'h0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dq_oe", 32'(bus.dq_oe), 0);
    check("rst_dq_out", 32'(bus.dq_out), 0);
    check("rst_mem_rd", 32'(bus.mem_rd), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_bytes_sent", 32'(bytes_sent), 0);
    check("rst_pulses", 32'({txn_done, cmd_err}), 0);

    mem[24'h200000] = 8'hA5;
    mem[24'h200001] = 8'h3C;
    quad_read(24'h200000, 4);
    id_read();
    bad_cmd(8'h05, 32);
    quad_read(24'hFFFFFF, 6);
    quad_read(24'($urandom), 1);

    // Abort inside the address phase, then a normal read must still decode.
    cs_low();
    send_bits(32'h6B, 8);
    send_bits(32'h123, 12);
    repeat (HALF) @(negedge clk);
    bus.spi_csn = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("abort_dq_oe", 32'(bus.dq_oe), 0);
    repeat (4 * HALF) @(negedge clk);
    drain("abort");
    quad_read(24'($urandom), 5);

    // Reset in the middle of the data phase.
    a = 24'($urandom);
    push_quad(a, 3);
    cs_low();
    send_bits(32'h6B, 8);
    send_bits(32'(a), 24);
    send_bits(0, DUMMY);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) sck_cycle(4'h0);
    mon_en = 1'b0;
    repeat (HALF) @(negedge clk);
    check("qdata_oe", 32'(bus.dq_oe), 32'hF);
    check("qdata_bytes", 32'(bytes_sent), 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_dq_oe", 32'(bus.dq_oe), 0);
    check("reset_bytes", 32'(bytes_sent), 0);
    reset = 1'b0;
    bus.spi_csn = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    drain("reset");

    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 3))
        0: quad_read(24'($urandom), $urandom_range(1, 9));
        1: quad_read(24'hFFFFFF - 24'($urandom_range(0, 3)), $urandom_range(2, 9));
        2: id_read();
        default: begin
          op = 8'($urandom);
          if (op == 8'h6B || op == 8'h9F) op = 8'h03;
          bad_cmd(op, 8);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end
endmodule
